// File: rtl/sipo_reg.sv
// ============================================================================
//  Module      : sipo_reg
//  Description : Serial-in, parallel-out shift register; one bit per clk edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sipo_reg #(
  parameter int                 WIDTH     = 4,
  parameter bit                 SHIFT_MSB = 1'b1,
  parameter logic [WIDTH-1:0]   RST_VAL   = '0
) (
  input  logic             d,
  input  logic             clk,
  output logic [WIDTH-1:0] q,
  input  logic             rst
);

  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] shift_q;

  // Direction is fixed at elaboration; d is the entry bit at one end.
  generate
    if (SHIFT_MSB) begin : g_shift_msb
      always_comb shift_d = {d, shift_q[WIDTH-1:1]};
    end else begin : g_shift_lsb
      always_comb shift_d = {shift_q[WIDTH-2:0], d};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= RST_VAL;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q = shift_q;

endmodule

`default_nettype wire

// File: tb/tb_sipo_reg.sv
// ============================================================================
//  Module      : tb_sipo_reg
//  Description : Table-driven self-checking bench for sipo_reg.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sipo_reg;

  logic       clk;
  logic       rst;
  logic       rst_tie;
  logic       d;
  logic [3:0] q_msb;
  logic [3:0] q_lsb;
  logic [3:0] q_nc;
  logic [7:0] q_wide;

  int errors;
  int checks;

  typedef struct {
    logic       d;
    logic [3:0] e_msb;
    logic [3:0] e_lsb;
    logic [7:0] e_wide;
    logic       chk_nc;
    logic [3:0] e_nc;
  } vec_t;

  vec_t tab_a[6];
  vec_t tab_b[5];

  sipo_reg #(.WIDTH(4), .SHIFT_MSB(1'b1), .RST_VAL(4'h0)) u_msb (
    .d(d), .clk(clk), .q(q_msb), .rst(rst)
  );
  sipo_reg #(.WIDTH(4), .SHIFT_MSB(1'b0), .RST_VAL(4'h0)) u_lsb (
    .d(d), .clk(clk), .q(q_lsb), .rst(rst)
  );
  sipo_reg #(.WIDTH(4), .SHIFT_MSB(1'b1), .RST_VAL(4'h0)) u_nc (
    .d(d), .clk(clk), .q(q_nc), .rst(rst_tie)
  );
  sipo_reg #(.WIDTH(8), .SHIFT_MSB(1'b1), .RST_VAL(8'hA5)) u_wide (
    .d(d), .clk(clk), .q(q_wide), .rst(rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive d, let one posedge shift it, then compare.
  task automatic apply(input vec_t v, input string tag);
    d = v.d;
    @(posedge clk);
    #2 d = ~d;
    #1 d = ~d;
    @(negedge clk);
    check({tag, " msb"},  {4'h0, q_msb},  {4'h0, v.e_msb});
    check({tag, " lsb"},  {4'h0, q_lsb},  {4'h0, v.e_lsb});
    check({tag, " wide"}, q_wide,         v.e_wide);
    if (v.chk_nc) check({tag, " nc"}, {4'h0, q_nc}, {4'h0, v.e_nc});
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b0;
    rst_tie = 1'b0;
    d       = 1'b0;

    // Scenario A: d = 1,0,1,1 then 1,1; wide starts from 0x52 (one d=0 shift after reset).
    tab_a[0] = '{1'b1, 4'b1000, 4'b0001, 8'hA9, 1'b0, 4'h0};
    tab_a[1] = '{1'b0, 4'b0100, 4'b0010, 8'h54, 1'b0, 4'h0};
    tab_a[2] = '{1'b1, 4'b1010, 4'b0101, 8'hAA, 1'b0, 4'h0};
    tab_a[3] = '{1'b1, 4'b1101, 4'b1011, 8'hD5, 1'b1, 4'b1101};
    tab_a[4] = '{1'b1, 4'b1110, 4'b0111, 8'hEA, 1'b1, 4'b1110};
    tab_a[5] = '{1'b1, 4'b1111, 4'b1111, 8'hF5, 1'b1, 4'b1111};
    // Scenario B: after a mid-stream reset, d = 1,0,0,0,0.
    tab_b[0] = '{1'b1, 4'b1000, 4'b0001, 8'hD2, 1'b1, 4'b1111};
    tab_b[1] = '{1'b0, 4'b0100, 4'b0010, 8'h69, 1'b1, 4'b0111};
    tab_b[2] = '{1'b0, 4'b0010, 4'b0100, 8'h34, 1'b1, 4'b0011};
    tab_b[3] = '{1'b0, 4'b0001, 4'b1000, 8'h1A, 1'b1, 4'b0001};
    tab_b[4] = '{1'b0, 4'b0000, 4'b0000, 8'h0D, 1'b1, 4'b0000};

    // Asynchronous reset pulse with no clock edge in between.
    #2 rst = 1'b1;
    #0.5;
    check("async rst msb",  {4'h0, q_msb}, 8'h00);
    check("async rst lsb",  {4'h0, q_lsb}, 8'h00);
    check("async rst wide", q_wide,        8'hA5);
    #0.5 rst = 1'b0;
    #1;
    check("post release hold wide", q_wide, 8'hA5);

    // First edge after release (t=5) shifts d=0.
    @(negedge clk);
    check("first edge msb",  {4'h0, q_msb}, 8'h00);
    check("first edge wide", q_wide,        8'h52);

    for (int i = 0; i < 6; i++) apply(tab_a[i], $sformatf("A%0d", i));

    // Mid-stream reset between edges clears everything at once and holds.
    #2 rst = 1'b1;
    d = 1'b1;
    #1;
    check("mid rst msb",  {4'h0, q_msb}, 8'h00);
    check("mid rst lsb",  {4'h0, q_lsb}, 8'h00);
    check("mid rst wide", q_wide,        8'hA5);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("rst hold msb %0d", k),  {4'h0, q_msb}, 8'h00);
      check($sformatf("rst hold wide %0d", k), q_wide,        8'hA5);
    end
    rst = 1'b0;

    for (int i = 0; i < 5; i++) apply(tab_b[i], $sformatf("B%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
